// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and helpers for the instruction-fetch controller:
// fetch FIFO entry, debug-port state and the ROM address legality check.
package imem_ctrl_pkg;

   localparam int unsigned IMEM_BYTES_DEFAULT = 1024;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      DBG_IDLE = 1'b0,
      DBG_ACK  = 1'b1
   } dbg_state_t;

   // Written as addr < bytes-3 so a huge address cannot wrap past the bound.
   function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] bytes);
      return (addr[1:0] == 2'b00) && (addr < bytes - 64'd3);
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// IF/ID output handshake and debug read port of the fetch controller.
// master = controller side, slave = consumer / debug requester side.
interface imem_fetch_ctrl_if;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;

   logic        dbg_req;
   logic [63:0] dbg_addr;
   logic        dbg_ack;
   logic [31:0] dbg_rdata;
   logic        dbg_err;

   modport master (
      output out_valid, out_instr, out_pc, dbg_ack, dbg_rdata, dbg_err,
      input  out_ready, dbg_req, dbg_addr
   );

   modport slave (
      input  out_valid, out_instr, out_pc, dbg_ack, dbg_rdata, dbg_err,
      output out_ready, dbg_req, dbg_addr
   );

endinterface

// File: rtl/imem_fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush overrides push and pop.
// The head is read straight from the storage registers.
module imem_fetch_fifo
   import imem_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             din,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [CW-1:0]  cnt;

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer and ROM-port arbiter: owns the fetch PC, shares the ROM with
// a debug reader, detects illegal fetch PCs and feeds a prefetch FIFO to IF/ID.
module imem_fetch_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [63:0] RESET_PC   = 64'd0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   output logic [63:0]               imem_addr,
   input  logic [31:0]               imem_rdata,
   input  logic                      redirect_valid,
   input  logic [63:0]               redirect_pc,
   imem_fetch_ctrl_if.master         bus,
   output logic                      fault,
   output logic [63:0]               fault_pc
);

   localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [63:0] BYTES = 64'(IMEM_BYTES);

   dbg_state_t    dbg_state;
   dbg_state_t    dbg_next;
   logic          dbg_grant;
   logic          dbg_legal;
   logic [31:0]   dbg_rdata;
   logic          dbg_err;

   logic [63:0]   fpc;
   logic          fpc_legal;
   logic          fetch_live;
   logic          push;
   logic          pop;
   logic          set_fault;
   logic [CW-1:0] count;
   fetch_entry_t  entry;
   fetch_entry_t  head;

   // A grant always leads to one ACK cycle, so debug can never win twice in a row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dbg_state <= DBG_IDLE;
      else          dbg_state <= dbg_next;
   end

   always_comb begin
      dbg_next  = DBG_IDLE;
      dbg_grant = 1'b0;
      case (dbg_state)
         DBG_IDLE: begin
            if (bus.dbg_req) begin
               dbg_grant = 1'b1;
               dbg_next  = DBG_ACK;
            end
         end
         DBG_ACK: dbg_next = DBG_IDLE;
      endcase
   end

   assign dbg_legal = addr_ok(bus.dbg_addr, BYTES);
   assign imem_addr = (dbg_grant && dbg_legal) ? bus.dbg_addr : fpc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dbg_rdata <= '0;
         dbg_err   <= 1'b0;
      end else if (dbg_grant) begin
         dbg_rdata <= dbg_legal ? imem_rdata : 32'd0;
         dbg_err   <= !dbg_legal;
      end
   end

   assign bus.dbg_ack   = (dbg_state == DBG_ACK);
   assign bus.dbg_rdata = dbg_rdata;
   assign bus.dbg_err   = dbg_err;

   assign fpc_legal  = addr_ok(fpc, BYTES);
   assign fetch_live = !dbg_grant && !fault && !redirect_valid;
   assign pop        = bus.out_valid && bus.out_ready;
   assign push       = fetch_live && fpc_legal && ((count < CW'(FIFO_DEPTH)) || pop);
   assign set_fault  = fetch_live && !fpc_legal;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fpc      <= RESET_PC;
         fault    <= 1'b0;
         fault_pc <= '0;
      end else if (redirect_valid) begin
         fpc   <= redirect_pc;
         fault <= 1'b0;
      end else begin
         if (push) fpc <= fpc + 64'd4;
         if (set_fault) begin
            fault    <= 1'b1;
            fault_pc <= fpc;
         end
      end
   end

   assign entry.pc    = fpc;
   assign entry.instr = imem_rdata;

   imem_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .din     (entry),
      .count   (count),
      .head    (head)
   );

   assign bus.out_valid = (count != '0);
   assign bus.out_instr = head.instr;
   assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the fetch/debug rules.
module tb_imem_fetch_ctrl;
   import imem_ctrl_pkg::*;

   localparam int unsigned BYTES = 1024;
   localparam int unsigned DEPTH = 4;
   localparam logic [63:0] RPC   = 64'd0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        fault;
   logic [63:0] fault_pc;

   imem_fetch_ctrl_if bus();

   imem_fetch_ctrl #(
      .IMEM_BYTES (BYTES),
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (RPC)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus),
      .fault          (fault),
      .fault_pc       (fault_pc)
   );

   always #5 clk = ~clk;

   logic [31:0] rom [256];
   always_comb imem_rdata = (imem_addr < 64'(BYTES)) ? rom[imem_addr[9:2]] : 32'hDEAD_BEEF;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   fetch_entry_t m_q[$];
   logic [63:0]  m_fpc, m_fault_pc;
   logic [31:0]  m_drdata;
   bit           m_fault, m_ack, m_prev, m_derr;

   function automatic bit legal(input logic [63:0] a);
      return (a % 4 == 0) && (a + 3 < 64'(BYTES));
   endfunction

   function automatic bit m_grant();
      return bus.dbg_req && !m_ack && !m_prev;
   endfunction

   function automatic logic [63:0] m_addr();
      return (m_grant() && legal(bus.dbg_addr)) ? bus.dbg_addr : m_fpc;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_fpc = RPC; m_fault = 0; m_fault_pc = '0;
      m_ack = 0; m_prev = 0; m_drdata = '0; m_derr = 0;
   endtask

   // Advance model and DUT by one clock; returns at the following negedge.
   task automatic tick();
      bit g;
      fetch_entry_t e;
      g = m_grant();
      if (redirect_valid) begin
         m_q.delete();
         m_fpc   = redirect_pc;
         m_fault = 0;
      end else begin
         if (m_q.size() > 0 && bus.out_ready) m_q.delete(0);
         if (!g && !m_fault) begin
            if (!legal(m_fpc)) begin
               m_fault = 1;
               m_fault_pc = m_fpc;
            end else if (m_q.size() < DEPTH) begin
               e.pc = m_fpc;
               e.instr = rom[m_fpc[9:2]];
               m_q.push_back(e);
               m_fpc = m_fpc + 4;
            end
         end
      end
      if (g) begin
         m_drdata = legal(bus.dbg_addr) ? rom[bus.dbg_addr[9:2]] : 32'd0;
         m_derr   = !legal(bus.dbg_addr);
      end
      m_ack  = g;
      m_prev = g;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 0; redirect_valid = 0; redirect_pc = '0;
      bus.out_ready = 0; bus.dbg_req = 0; bus.dbg_addr = '0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1;
   endtask

   task automatic test_reset();
      reset_n = 0; redirect_valid = 0; redirect_pc = '0;
      bus.out_ready = 1; bus.dbg_req = 0; bus.dbg_addr = '0;
      model_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", fault); end
      n_cmp++; if (fault_pc !== 64'd0) begin n_bad++; $display("FAIL reset_fault_pc got %h want 0", fault_pc); end
      n_cmp++; if (bus.dbg_ack !== 1'b0 || bus.dbg_err !== 1'b0) begin n_bad++; $display("FAIL reset_dbg ack=%b err=%b want 0 0", bus.dbg_ack, bus.dbg_err); end
      n_cmp++; if (bus.dbg_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_dbg_rdata got %h want 0", bus.dbg_rdata); end
      n_cmp++; if (imem_addr !== RPC) begin n_bad++; $display("FAIL reset_imem_addr got %h want %h", imem_addr, RPC); end
      reset_n = 1;
   endtask

   task automatic test_stream();
      bus.out_ready = 1;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * i) || bus.out_instr !== rom[i]) begin
            n_bad++;
            $display("FAIL stream[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                     i, bus.out_valid, bus.out_pc, bus.out_instr, 4 * i, rom[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.out_ready = 0;
      repeat (10) tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'd0) begin n_bad++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
      n_cmp++; if (imem_addr !== 64'd16) begin n_bad++; $display("FAIL bp_stall_fpc got %h want 10", imem_addr); end
      bus.out_ready = 1;
      for (int k = 0; k < 6; k++) begin
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 * k) || bus.out_instr !== rom[k]) begin
            n_bad++;
            $display("FAIL bp_drain[%0d] got v=%b pc=%h want pc=%h", k, bus.out_valid, bus.out_pc, 4 * k);
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      bus.out_ready = 0;
      repeat (3) tick();
      redirect_valid = 1; redirect_pc = 64'h40; bus.out_ready = 1'($urandom % 2);
      tick();
      redirect_valid = 0;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush got v=%b want 0", bus.out_valid); end
      bus.out_ready = 1;
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h40 || bus.out_instr !== rom[16]) begin
         n_bad++; $display("FAIL redir_first got v=%b pc=%h want v=1 pc=40", bus.out_valid, bus.out_pc);
      end
      for (int k = 0; k < 12; k++) begin
         bus.out_ready = 1'($urandom % 2);
         tick();
         n_cmp++;
         if (bus.out_valid !== (m_q.size() != 0) || (m_q.size() != 0 &&
             (bus.out_pc !== m_q[0].pc || bus.out_pc < 64'h40))) begin
            n_bad++; $display("FAIL redir_after[%0d] got v=%b pc=%h want v=%0d", k, bus.out_valid, bus.out_pc, m_q.size() != 0);
         end
      end
   endtask

   task automatic test_fault();
      logic [63:0] got[$];
      do_reset();
      bus.out_ready = 1; redirect_valid = 1; redirect_pc = 64'h3F8;
      tick();
      redirect_valid = 0;
      repeat (6) begin
         if (bus.out_valid === 1'b1) got.push_back(bus.out_pc);
         tick();
      end
      n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL fault_count got %0d want 2", got.size()); end
      else begin
         n_cmp++; if (got[0] !== 64'h3F8 || got[1] !== 64'h3FC) begin n_bad++; $display("FAIL fault_pcs got %h %h want 3f8 3fc", got[0], got[1]); end
      end
      n_cmp++; if (fault !== 1'b1 || fault_pc !== 64'h400) begin n_bad++; $display("FAIL fault_set got f=%b pc=%h want f=1 pc=400", fault, fault_pc); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL fault_drained got v=%b want 0", bus.out_valid); end
      redirect_valid = 1; redirect_pc = 64'd0;
      tick();
      redirect_valid = 0;
      n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_clear got %b want 0", fault); end
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'd0) begin n_bad++; $display("FAIL fault_resume got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
   endtask

   task automatic dbg_single(input logic [63:0] addr);
      bit got = 0;
      bus.dbg_req = 0;
      tick();
      bus.dbg_addr = addr; bus.dbg_req = 1;
      for (int c = 0; c < 6 && !got; c++) begin
         tick();
         if (m_ack) got = 1;
      end
      n_cmp++;
      if (!got || bus.dbg_ack !== 1'b1 || bus.dbg_err !== 1'b1 || bus.dbg_rdata !== 32'd0) begin
         n_bad++; $display("FAIL dbg_bad_addr %h got ack=%b err=%b rdata=%h want 1 1 0", addr, bus.dbg_ack, bus.dbg_err, bus.dbg_rdata);
      end
      bus.dbg_req = 0;
   endtask

   task automatic test_debug();
      bit prev_ack = 0;
      int acks = 0;
      do_reset();
      bus.out_ready = 1; bus.dbg_req = 1; bus.dbg_addr = 64'h8;
      for (int c = 0; c < 24; c++) begin
         #1;
         n_cmp++; if (imem_addr !== m_addr()) begin n_bad++; $display("FAIL dbg_imem_addr[%0d] got %h want %h", c, imem_addr, m_addr()); end
         tick();
         n_cmp++; if (bus.dbg_ack !== m_ack || (prev_ack && bus.dbg_ack)) begin n_bad++; $display("FAIL dbg_ack[%0d] got %b want %b", c, bus.dbg_ack, m_ack); end
         if (bus.dbg_ack === 1'b1) begin
            acks++;
            n_cmp++; if (bus.dbg_rdata !== rom[2] || bus.dbg_err !== 1'b0) begin n_bad++; $display("FAIL dbg_data got %h err=%b want %h err=0", bus.dbg_rdata, bus.dbg_err, rom[2]); end
         end
         n_cmp++; if (bus.out_valid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.out_pc !== m_q[0].pc)) begin
            n_bad++; $display("FAIL dbg_stream[%0d] got v=%b pc=%h", c, bus.out_valid, bus.out_pc);
         end
         prev_ack = bus.dbg_ack;
      end
      n_cmp++; if (acks != 12) begin n_bad++; $display("FAIL dbg_ack_count got %0d want 12", acks); end
      dbg_single(64'h6);
      dbg_single(64'h400);
   endtask

   task automatic test_async_reset();
      bit got = 0;
      do_reset();
      bus.out_ready = 1;
      repeat (3) tick();
      bus.dbg_addr = 64'h8; bus.dbg_req = 1;
      for (int c = 0; c < 4 && !got; c++) begin
         tick();
         if (m_ack) got = 1;
      end
      n_cmp++; if (!got || bus.dbg_ack !== 1'b1) begin n_bad++; $display("FAIL arst_pre_ack got %b want 1", bus.dbg_ack); end
      #2;
      reset_n = 0; bus.dbg_req = 0;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.dbg_ack !== 1'b0) begin n_bad++; $display("FAIL arst_ctrl got v=%b ack=%b want 0 0", bus.out_valid, bus.dbg_ack); end
      n_cmp++; if (bus.dbg_rdata !== 32'd0 || bus.dbg_err !== 1'b0) begin n_bad++; $display("FAIL arst_dbg got %h err=%b want 0 0", bus.dbg_rdata, bus.dbg_err); end
      n_cmp++; if (fault !== 1'b0 || fault_pc !== 64'd0 || imem_addr !== RPC) begin n_bad++; $display("FAIL arst_fetch got f=%b fpc=%h addr=%h", fault, fault_pc, imem_addr); end
      model_reset();
      @(negedge clk);
      reset_n = 1;
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC || bus.out_instr !== rom[0]) begin
         n_bad++; $display("FAIL arst_restart got v=%b pc=%h want v=1 pc=%h", bus.out_valid, bus.out_pc, RPC);
      end
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         n_cmp++;
         if (bus.out_valid !== (m_q.size() != 0) || (m_q.size() != 0 &&
             (bus.out_pc !== m_q[0].pc || bus.out_instr !== m_q[0].instr))) begin
            n_bad++; $display("FAIL rnd_out[%0d] got v=%b pc=%h want v=%0d", c, bus.out_valid, bus.out_pc, m_q.size() != 0);
         end
         n_cmp++; if (fault !== m_fault || fault_pc !== m_fault_pc) begin n_bad++; $display("FAIL rnd_fault[%0d] got %b %h want %b %h", c, fault, fault_pc, m_fault, m_fault_pc); end
         n_cmp++; if (bus.dbg_ack !== m_ack || (m_ack && (bus.dbg_rdata !== m_drdata || bus.dbg_err !== m_derr))) begin
            n_bad++; $display("FAIL rnd_dbg[%0d] got %b %h %b want %b %h %b", c, bus.dbg_ack, bus.dbg_rdata, bus.dbg_err, m_ack, m_drdata, m_derr);
         end
         bus.out_ready = ($urandom % 4) != 0;
         redirect_valid = ($urandom % 20) == 0;
         r = $urandom % 8;
         if (r < 6)       redirect_pc = 64'(($urandom % 256) * 4);
         else if (r == 6) redirect_pc = 64'h3F0 + 64'(($urandom % 4) * 4);
         else             redirect_pc = 64'(($urandom % 1024) | 1);
         if (m_ack) bus.dbg_req = 0;
         else if (!bus.dbg_req && ($urandom % 6) == 0) begin
            bus.dbg_req = 1;
            bus.dbg_addr = (($urandom % 4) != 0) ? 64'(($urandom % 256) * 4) : 64'(($urandom % 2048) | 2);
         end
         #1;
         n_cmp++; if (imem_addr !== m_addr()) begin n_bad++; $display("FAIL rnd_addr[%0d] got %h want %h", c, imem_addr, m_addr()); end
         tick();
      end
      redirect_valid = 0; bus.dbg_req = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      bus.out_ready = 0; bus.dbg_req = 0; bus.dbg_addr = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fault();
      test_debug();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
